// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the ADC sample conditioning path.
//   cond_state_e : handshake FSM states of adc_sample_conditioner
//   adc_code_t   : raw 12-bit offset-binary ADC code
//   sample_t     : 16-bit signed full-scale audio sample
//   ADC_MIDSCALE : offset-binary code that represents 0 V
//   sat_inc8     : 8-bit increment that sticks at 8'hFF
// ---------------------------------------------------------------------------
package audio_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_OUT  = 2'd2
   } cond_state_e;

   typedef logic        [11:0] adc_code_t;
   typedef logic signed [15:0] sample_t;

   localparam logic [11:0] ADC_MIDSCALE = 12'd2048;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
   endfunction

endpackage

// File: rtl/sample_delay_line.sv
// ---------------------------------------------------------------------------
// sample_delay_line
// Register ring holding the last DEPTH samples of the moving-average window.
// The entry under the write pointer is the oldest one; it is presented
// combinationally so the caller can subtract it in the same cycle that the
// new sample overwrites it.
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset, clears every entry and the pointer
//   wr_en   : write wr_data at the pointer and advance the pointer
//   wr_data : sample to store (W bits)
//   oldest  : entry that the next write will overwrite (W bits)
// ---------------------------------------------------------------------------
module sample_delay_line #(
   parameter int DEPTH = 8,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] oldest
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;

   assign oldest = mem_r[wr_ptr_r];

   // Ring storage and write pointer; DEPTH is a power of two so the pointer wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
      end else if (wr_en) begin
         mem_r[wr_ptr_r] <= wr_data;
         wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
   end

endmodule

// File: rtl/adc_sample_conditioner.sv
// ---------------------------------------------------------------------------
// adc_sample_conditioner
// Removes the mid-scale bias from raw offset-binary ADC codes, smooths them
// with a 2^AVG_LOG2-tap moving average and hands a full-scale signed sample
// to the effect chain over a valid/ready handshake. One sample is in flight
// at a time (IDLE -> CALC -> OUT). Refused input cycles are counted.
// Optional feature macro: ADC_COND_PEAK_METER_EN builds a decaying peak-hold
// meter on peak_level; without it peak_level is tied to zero.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   in_valid   : in_data holds a new ADC code
//   in_data    : ADC code, offset binary (DATA_W bits)
//   in_ready   : high while idle, input is taken this cycle
//   out_valid  : out_data holds a conditioned sample
//   out_data   : signed conditioned sample (OUT_W bits)
//   out_ready  : consumer accepts out_data
//   drop_cnt   : saturating count of cycles with in_valid && !in_ready
//   peak_level : |sample| peak hold, MSB aligned
// ---------------------------------------------------------------------------
module adc_sample_conditioner
   import audio_pkg::*;
#(
   parameter int DATA_W          = 12,
   parameter int AVG_LOG2        = 3,
   parameter int OUT_W           = 16,
   parameter int PEAK_DECAY_LOG2 = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_data,
   input  logic                    out_ready,
   output logic [7:0]              drop_cnt,
   output logic [7:0]              peak_level
);

   localparam int SUM_W = DATA_W + AVG_LOG2;
   localparam logic [DATA_W-1:0] MIDSCALE_C = {1'b1, {(DATA_W-1){1'b0}}};

   if (OUT_W < DATA_W) begin : g_cfg_out_w
      $error("adc_sample_conditioner: OUT_W must be >= DATA_W");
   end
   if (PEAK_DECAY_LOG2 < 1) begin : g_cfg_decay
      $error("adc_sample_conditioner: PEAK_DECAY_LOG2 must be >= 1");
   end

   cond_state_e              state_r, state_nxt_s;
   logic signed [DATA_W-1:0] sample_r;
   logic signed [SUM_W-1:0]  sum_r, sum_nxt_s, avg_s;
   logic signed [OUT_W-1:0]  out_data_r, out_nxt_s;
   logic [DATA_W-1:0]        oldest_s;
   logic [7:0]               drop_cnt_r;
   logic                     in_ready_s, out_valid_s, out_xfer_s, calc_s;

   // Handshake flags come straight from the state register, so they are glitch free.
   assign in_ready_s  = (state_r == S_IDLE);
   assign out_valid_s = (state_r == S_OUT);
   assign calc_s      = (state_r == S_CALC);
   assign out_xfer_s  = out_valid_s && out_ready;

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_data  = out_data_r;
   assign drop_cnt  = drop_cnt_r;

   sample_delay_line #(
      .DEPTH (2 ** AVG_LOG2),
      .W     (DATA_W)
   ) u_delay (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (calc_s),
      .wr_data (sample_r),
      .oldest  (oldest_s)
   );

   // Running sum update and scaling to full-scale output; the sum can never overflow SUM_W.
   always_comb begin
      sum_nxt_s = sum_r + SUM_W'(sample_r) - SUM_W'($signed(oldest_s));
      avg_s     = sum_nxt_s >>> AVG_LOG2;
      out_nxt_s = OUT_W'(avg_s) <<< (OUT_W - DATA_W);
   end

   // FSM next-state logic: one sample in flight, input refused outside S_IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid) state_nxt_s = S_CALC;
            else          state_nxt_s = S_IDLE;
         end
         S_CALC: state_nxt_s = S_OUT;
         S_OUT: begin
            if (out_ready) state_nxt_s = S_IDLE;
            else           state_nxt_s = S_OUT;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register, bias removal on accept and averaged sample capture in S_CALC.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_IDLE;
         sample_r   <= '0;
         sum_r      <= '0;
         out_data_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (in_ready_s && in_valid) begin
            sample_r <= $signed(in_data - MIDSCALE_C);
         end
         if (calc_s) begin
            sum_r      <= sum_nxt_s;
            out_data_r <= out_nxt_s;
         end
      end
   end

   // Drop counter: every cycle an offered sample is refused, including output stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_r <= 8'd0;
      end else if (in_valid && !in_ready_s) begin
         drop_cnt_r <= sat_inc8(drop_cnt_r);
      end
   end

`ifdef ADC_COND_PEAK_METER_EN
   logic [PEAK_DECAY_LOG2-1:0] decay_cnt_r;
   logic [7:0]                 peak_r, mag8_s;
   logic [OUT_W-1:0]           mag_s;

   // Magnitude of the sample being handed over; the most negative code saturates to full scale.
   always_comb begin
      if (out_data_r == {1'b1, {(OUT_W-1){1'b0}}}) begin
         mag_s = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (out_data_r[OUT_W-1]) begin
         mag_s = ~out_data_r + OUT_W'(1);
      end else begin
         mag_s = out_data_r;
      end
      mag8_s = mag_s[OUT_W-2 -: 8];
   end

   // Peak hold with slow linear decay; a new peak on the same cycle beats the decay step.
   always_ff @(posedge clk) begin
      if (reset) begin
         decay_cnt_r <= '0;
         peak_r      <= 8'd0;
      end else begin
         decay_cnt_r <= decay_cnt_r + PEAK_DECAY_LOG2'(1);
         if (out_xfer_s) begin
            if (mag8_s > peak_r) peak_r <= mag8_s;
         end else if ((decay_cnt_r == '1) && (peak_r != 8'd0)) begin
            peak_r <= peak_r - 8'd1;
         end
      end
   end

   assign peak_level = peak_r;
`else
   assign peak_level = 8'd0;
`endif

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_conditioner
// Scoreboard bench: an input-side process models the block from its rules
// (one sample in flight, moving average over the last 8 centred samples,
// saturating drop count) and queues expected outputs; an output-side process
// pops and compares on every output transfer. Directed sequences cover the
// reset state, mid-scale, ramp, negative full scale, backpressure, drop
// saturation and reset in S_OUT; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_adc_sample_conditioner;
   import audio_pkg::*;

   logic      clk = 1'b0;
   logic      reset, in_valid, in_ready, out_valid, out_ready;
   adc_code_t in_data;
   sample_t   out_data;
   logic [7:0] drop_cnt, peak_level;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit checks_on = 1'b0;

   int exp_q[$];
   int acc_q[$];
   int hist[$];
   bit pending = 1'b0;
   int exp_drop = 0;
   int exp_peak = 0;
   bit valid_seen = 1'b0;
   sample_t held;
   int xfer_cnt = 0;
   int last_out = 0;

   adc_sample_conditioner dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .drop_cnt   (drop_cnt),
      .peak_level (peak_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void clear_hist();
      hist.delete();
      repeat (8) hist.push_back(0);
   endfunction

   // Mean of the last eight centred samples, rounded toward minus infinity, scaled by 16.
   function automatic int model_out(input int code);
      int s, sum, q;
      s = code - int'(ADC_MIDSCALE);
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      q = sum / 8;
      if (sum < 0 && (sum % 8) != 0) q = q - 1;
      return q * 16;
   endfunction

   // Input side: predict readiness and drops, queue the expected output of each accepted code.
   always @(negedge clk) begin : in_side
      bit was_pending;
      if (reset) begin
         pending  = 1'b0;
         exp_drop = 0;
         exp_q.delete();
         acc_q.delete();
         clear_hist();
      end else if (checks_on) begin
         check("in_ready", int'(in_ready), int'(!pending));
         check("drop_cnt", int'(drop_cnt), exp_drop);
         was_pending = pending;
         if (out_valid && out_ready) pending = 1'b0;
         if (in_valid) begin
            if (was_pending) begin
               if (exp_drop < 255) exp_drop++;
            end else begin
               exp_q.push_back(model_out(int'(in_data)));
               acc_q.push_back(cyc);
               pending = 1'b1;
            end
         end
      end
   end

   // Output side: latency, stability while stalled, value on transfer, peak meter.
   always @(negedge clk) begin : out_side
      int v, m;
      if (reset) begin
         valid_seen = 1'b0;
         exp_peak   = 0;
      end else if (checks_on) begin
         check("peak_level", int'(peak_level), exp_peak);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_valid: got out_valid=1, expected 0 with nothing outstanding (cycle %0d)", cyc);
            end else begin
               if (!valid_seen) begin
                  check("latency", cyc - acc_q[0], 2);
                  held       = out_data;
                  valid_seen = 1'b1;
               end else begin
                  check("out_stable", int'(out_data), int'(held));
               end
               if (out_ready) begin
                  v = exp_q.pop_front();
                  void'(acc_q.pop_front());
                  check("out_data", int'(out_data), v);
                  last_out   = int'(out_data);
                  xfer_cnt++;
                  valid_seen = 1'b0;
`ifdef ADC_COND_PEAK_METER_EN
                  m = (v < 0) ? -v : v;
                  if (m > 32767) m = 32767;
                  if ((m / 128) > exp_peak) exp_peak = m / 128;
`else
                  m = 0;
`endif
               end
            end
         end else if (exp_q.size() != 0 && (cyc - acc_q[0]) >= 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_valid: got out_valid=0, expected 1 for sample accepted at cycle %0d (cycle %0d)", acc_q[0], cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Offer one code as soon as the block is idle (bounded wait).
   task automatic send(input int code);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0, expected 1 within 20 cycles");
      end
      in_valid = 1'b1;
      in_data  = 12'(code);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      int x0, n;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_data", int'(out_data), 0);
      check("rst_drop_cnt", int'(drop_cnt), 0);
      check("rst_peak", int'(peak_level), 0);
      checks_on = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Mid-scale in gives silence out.
      for (int i = 0; i < 10; i++) send(2048);
      idle(3);
      check("mid_last", last_out, 0);

      // Positive full-scale ramp over the warm-up window.
      send(4095);
      idle(3);
      check("ramp_first", last_out, 4080);
      for (int i = 0; i < 7; i++) send(4095);
      idle(3);
      check("ramp_eighth", last_out, 32752);
      send(4095);
      idle(3);
      check("ramp_ninth", last_out, 32752);

      // Negative full scale.
      for (int i = 0; i < 8; i++) send(0);
      idle(3);
      check("neg_full", last_out, -32768);
`ifdef ADC_COND_PEAK_METER_EN
      check("peak_full", int'(peak_level), 255);
`endif

      // Backpressure: input held valid while the consumer stalls.
      do_reset(2);
      out_ready = 1'b0; in_data = 12'd1000; in_valid = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_drop", int'(drop_cnt), 19);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      x0 = xfer_cnt;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      idle(6);
      check("bp_one_xfer", xfer_cnt - x0, 1);

      // Drop counter saturation.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 12'd3000;
      repeat (300) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("drop_sat", int'(drop_cnt), 255);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      idle(4);

      // Reset while a sample waits in S_OUT.
      out_ready = 1'b0;
      send(4095);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rst_mid_reach_out", int'(out_valid), 1);
      x0 = xfer_cnt;
      reset = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", int'(out_valid), 0);
      check("rst_mid_no_xfer", xfer_cnt - x0, 0);
      last_out = 12345;
      send(4095);
      idle(3);
      check("rst_mid_sum_clear", last_out, 4080);

      // Randomized traffic with random consumer stalls.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 2) == 0);
         in_data   = 12'($urandom_range(0, 4095));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      idle(6);
      check("drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
